// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: default bus
// widths, the arbiter state encoding and the data returned on a watchdog
// completion.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Arbiter is either waiting for a request or carrying one transaction
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Read data handed to a master whose transaction the watchdog completed
    localparam int unsigned TIMEOUT_RDATA = 0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native memory bus (picorv32 style): valid/instr/addr/wdata/wstrb forward,
// ready/rdata back. The master modport is the requester's view, the slave
// modport the responder's view.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic                valid;
    logic                instr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant decision. A lone requester always wins; on contention
// the winner is the master not served last (round robin) or master 0 (fixed
// priority). Purely combinational; the caller registers the result.
module rr_arb2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt
);

    // Resolve the winning master index from the current requests
    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one native-bus slave port between two masters, one whole
// transaction at a time. A watchdog force-completes transactions the slave
// never acknowledges and records that in a sticky error flag.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic              owner,
    output logic              timeout_err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    logic                gnt;
    logic                busy;
    logic                wd_expired;
    logic                done_ok;
    logic                done_to;
    logic                done;
    logic [DATA_W-1:0]   done_rdata;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W/8-1:0] own_wstrb;

    rr_arb2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_arb2 (
        .req        ({m1.valid, m0.valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    // Decode how (and whether) the current transaction finishes this cycle
    always_comb begin
        busy       = (state_q == ARB_BUSY);
        wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
        done_ok    = busy && s.ready;
        done_to    = busy && !s.ready && wd_expired;
        done       = done_ok || done_to;
        done_rdata = done_ok ? s.rdata : DATA_W'(TIMEOUT_RDATA);
    end

    // Next-state: grant in IDLE, count and complete in BUSY
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        timeout_err_d = timeout_err_q;
        wd_d          = wd_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0.valid || m1.valid) begin
                    state_d = ARB_BUSY;
                    owner_d = gnt;
                    wd_d    = '0;
                end
            end
            ARB_BUSY: begin
                if (s.ready) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = owner_q;
                end else if (wd_expired) begin
                    state_d       = ARB_IDLE;
                    last_grant_d  = owner_q;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset leaves master 0 as winner of the first contention
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ARB_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

    // Route the owner's request to the slave and the completion back to the owner only
    always_comb begin
        own_addr  = owner_q ? m1.addr  : m0.addr;
        own_wdata = owner_q ? m1.wdata : m0.wdata;
        own_wstrb = owner_q ? m1.wstrb : m0.wstrb;
        s.valid   = busy;
        s.instr   = owner_q ? m1.instr : m0.instr;
        s.addr    = own_addr;
        s.wdata   = own_wdata;
        s.wstrb   = own_wstrb;
        m0.ready  = done && !owner_q;
        m1.ready  = done && owner_q;
        m0.rdata  = (done && !owner_q) ? done_rdata : '0;
        m1.rdata  = (done && owner_q)  ? done_rdata : '0;
    end

    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. Two instances: one round-robin, one
// fixed-priority. Expected completions and slave requests are queued when a
// transaction is issued; monitors pop and compare whenever the DUT presents
// a ready (to a master) or a valid+ready handshake (to the slave).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int RR    = 0;
    localparam int FP    = 1;
    localparam int NEVER = -1;

    typedef struct {
        int          master;
        logic [31:0] rdata;
        int          busy;
        int          gap;
    } resp_t;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sreq_t;

    logic clk = 1'b0;
    logic resetn;
    logic owner_rr, terr_rr, owner_fp, terr_fp;

    resp_t       exp_rr[$];
    resp_t       exp_fp[$];
    sreq_t       exp_sreq[$];
    logic [31:0] slv_rdata_q[$];
    int          slv_lat;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_bus_arbiter_if m0_rr ();
    mem_bus_arbiter_if m1_rr ();
    mem_bus_arbiter_if s_rr ();
    mem_bus_arbiter_if m0_fp ();
    mem_bus_arbiter_if m1_fp ();
    mem_bus_arbiter_if s_fp ();

    mem_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(15)) dut_rr (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_rr),
        .m1          (m1_rr),
        .s           (s_rr),
        .owner       (owner_rr),
        .timeout_err (terr_rr)
    );

    mem_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(15)) dut_fp (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_fp),
        .m1          (m1_fp),
        .s           (s_fp),
        .owner       (owner_fp),
        .timeout_err (terr_fp)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pushResp(input int m, input logic [31:0] rd, input int b, input int g);
        resp_t r;
        r.master = m;
        r.rdata  = rd;
        r.busy   = b;
        r.gap    = g;
        exp_rr.push_back(r);
    endtask

    task automatic pushSreq(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] slave_rdata);
        sreq_t q;
        q.instr = instr;
        q.addr  = addr;
        q.wdata = wdata;
        q.wstrb = wstrb;
        exp_sreq.push_back(q);
        slv_rdata_q.push_back(slave_rdata);
    endtask

    task automatic pushFp(input int m, input logic [31:0] rd);
        resp_t r;
        r.master = m;
        r.rdata  = rd;
        r.busy   = 1;
        r.gap    = -1;
        exp_fp.push_back(r);
    endtask

    task automatic drive(input int d, input int m, input logic v, input logic instr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (d == RR && m == 0) begin
            m0_rr.valid = v; m0_rr.instr = instr; m0_rr.addr = addr; m0_rr.wdata = wdata; m0_rr.wstrb = wstrb;
        end else if (d == RR) begin
            m1_rr.valid = v; m1_rr.instr = instr; m1_rr.addr = addr; m1_rr.wdata = wdata; m1_rr.wstrb = wstrb;
        end else if (m == 0) begin
            m0_fp.valid = v; m0_fp.instr = instr; m0_fp.addr = addr; m0_fp.wdata = wdata; m0_fp.wstrb = wstrb;
        end else begin
            m1_fp.valid = v; m1_fp.instr = instr; m1_fp.addr = addr; m1_fp.wdata = wdata; m1_fp.wstrb = wstrb;
        end
    endtask

    function automatic logic readyOf(input int d, input int m);
        if (d == RR) return (m == 0) ? m0_rr.ready : m1_rr.ready;
        return (m == 0) ? m0_fp.ready : m1_fp.ready;
    endfunction

    // Issue one request, hold it until the master sees ready, then release it
    task automatic applyStimulus(input int d, input int m, input logic instr,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        bit got = 0;
        drive(d, m, 1'b1, instr, addr, wdata, wstrb);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readyOf(d, m)) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ready_wait dut%0d m%0d addr 0x%0h: got no ready, required ready within 100 cycles", d, m, addr);
        end
        @(posedge clk);
        #1;
        drive(d, m, 1'b0, instr, addr, wdata, wstrb);
    endtask

    // Round-robin slave: answers after slv_lat extra cycles (never if NEVER), junk rdata otherwise
    initial begin
        int cnt = 0;
        s_rr.ready = 1'b0;
        s_rr.rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            s_rr.ready = 1'b0;
            s_rr.rdata = 32'hDEAD_BEEF;
            if (s_rr.valid) begin
                if (slv_lat != NEVER && cnt == slv_lat) begin
                    s_rr.ready = 1'b1;
                    s_rr.rdata = (slv_rdata_q.size() > 0) ? slv_rdata_q.pop_front() : 32'h0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Fixed-priority slave: zero-latency, returns the address as read data
    initial begin
        s_fp.ready = 1'b0;
        s_fp.rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            s_fp.ready = s_fp.valid;
            s_fp.rdata = s_fp.valid ? s_fp.addr : 32'hDEAD_BEEF;
        end
    end

    // Round-robin monitor: tracks busy/idle run lengths and scores every handshake
    initial begin
        int    busy_len = 0;
        int    idle_len = 0;
        int    cur_gap  = 0;
        bit    prev_valid = 0;
        resp_t e;
        sreq_t q;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy_len = 0; idle_len = 0; prev_valid = 0;
                continue;
            end
            if (s_rr.valid) begin
                if (!prev_valid) begin
                    cur_gap  = idle_len;
                    busy_len = 0;
                end
                busy_len++;
            end else begin
                idle_len = prev_valid ? 1 : idle_len + 1;
            end
            prev_valid = s_rr.valid;
            if (s_rr.valid && s_rr.ready) begin
                if (exp_sreq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL unexpected_slave_handshake: got addr 0x%0h, required none", s_rr.addr);
                end else begin
                    q = exp_sreq.pop_front();
                    checkOutput("s_instr", s_rr.instr, q.instr);
                    checkOutput("s_addr",  s_rr.addr,  q.addr);
                    checkOutput("s_wdata", s_rr.wdata, q.wdata);
                    checkOutput("s_wstrb", s_rr.wstrb, q.wstrb);
                end
            end
            if (m0_rr.ready || m1_rr.ready) begin
                if (exp_rr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL unexpected_ready: got m0/m1 ready %b%b, required none", m0_rr.ready, m1_rr.ready);
                end else begin
                    e = exp_rr.pop_front();
                    checkOutput("ready_onehot", {m1_rr.ready, m0_rr.ready}, (e.master == 1) ? 2'b10 : 2'b01);
                    checkOutput("owner", owner_rr, e.master[0]);
                    checkOutput("rdata", (e.master == 1) ? m1_rr.rdata : m0_rr.rdata, e.rdata);
                    checkOutput("nonowner_rdata", (e.master == 1) ? m0_rr.rdata : m1_rr.rdata, 0);
                    checkOutput("busy_cycles", busy_len, e.busy);
                    if (e.gap >= 0) checkOutput("idle_gap", cur_gap, e.gap);
                end
            end
        end
    end

    // Fixed-priority monitor: order and data of completions
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (resetn && (m0_fp.ready || m1_fp.ready)) begin
                if (exp_fp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL fp_unexpected_ready: got m0/m1 ready %b%b, required none", m0_fp.ready, m1_fp.ready);
                end else begin
                    e = exp_fp.pop_front();
                    checkOutput("fp_ready_onehot", {m1_fp.ready, m0_fp.ready}, (e.master == 1) ? 2'b10 : 2'b01);
                    checkOutput("fp_rdata", (e.master == 1) ? m1_fp.rdata : m0_fp.rdata, e.rdata);
                end
            end
        end
    end

    // Backstop so a wedged run still ends
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got no end of test, required end before 300 us");
        $fatal(1, "[TB] simulation time limit");
    end

    // Directed test sequence
    initial begin
        resetn  = 1'b0;
        slv_lat = 0;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                drive(d, m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_valid", s_rr.valid, 0);
        checkOutput("rst_m0_ready", m0_rr.ready, 0);
        checkOutput("rst_m1_ready", m1_rr.ready, 0);
        checkOutput("rst_owner", owner_rr, 0);
        checkOutput("rst_timeout_err", terr_rr, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Contention from reset: m0 first, then m1 after a single idle cycle
        slv_lat = 1;
        pushResp(0, 32'h1111_0000, 2, -1);
        pushResp(1, 32'h2222_0000, 2, 1);
        pushSreq(1'b1, 32'h100, 32'h0, 4'h0, 32'h1111_0000);
        pushSreq(1'b0, 32'h200, 32'h0, 4'h0, 32'h2222_0000);
        fork
            applyStimulus(RR, 0, 1'b1, 32'h100, 32'h0, 4'h0);
            applyStimulus(RR, 1, 1'b0, 32'h200, 32'h0, 4'h0);
        join

        // m1 served last, so m0 wins the next contention again
        pushResp(0, 32'h3333_0000, 2, -1);
        pushResp(1, 32'h4444_0000, 2, 1);
        pushSreq(1'b0, 32'h300, 32'h0, 4'h0, 32'h3333_0000);
        pushSreq(1'b0, 32'h400, 32'h77, 4'h3, 32'h4444_0000);
        fork
            applyStimulus(RR, 0, 1'b0, 32'h300, 32'h0, 4'h0);
            applyStimulus(RR, 1, 1'b0, 32'h400, 32'h77, 4'h3);
        join

        // Single m0 read, slave answers after 2 cycles
        slv_lat = 2;
        pushResp(0, 32'hCAFE_0001, 3, -1);
        pushSreq(1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFE_0001);
        applyStimulus(RR, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        checkOutput("single_owner", owner_rr, 0);

        // m0 served last, so m1 now wins contention
        slv_lat = 1;
        pushResp(1, 32'h6666_0000, 2, -1);
        pushResp(0, 32'h5555_0000, 2, 1);
        pushSreq(1'b0, 32'h600, 32'h0, 4'h0, 32'h6666_0000);
        pushSreq(1'b0, 32'h500, 32'h0, 4'h0, 32'h5555_0000);
        fork
            applyStimulus(RR, 0, 1'b0, 32'h500, 32'h0, 4'h0);
            applyStimulus(RR, 1, 1'b0, 32'h600, 32'h0, 4'h0);
        join

        // m1 write with m0 carrying different idle values on its inputs
        slv_lat = 0;
        drive(RR, 0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 4'h1);
        pushResp(1, 32'h0000_005A, 1, -1);
        pushSreq(1'b0, 32'h1000_0000, 32'h5A, 4'hF, 32'h0000_005A);
        applyStimulus(RR, 1, 1'b0, 32'h1000_0000, 32'h5A, 4'hF);
        checkOutput("write_owner", owner_rr, 1);

        // Slave ready on the last watchdog cycle: normal completion, no error
        slv_lat = 14;
        pushResp(0, 32'h1357_2468, 15, -1);
        pushSreq(1'b0, 32'h40, 32'h0, 4'h0, 32'h1357_2468);
        applyStimulus(RR, 0, 1'b0, 32'h40, 32'h0, 4'h0);
        checkOutput("edge_no_timeout_err", terr_rr, 0);

        // Slave never answers: forced completion on the 15th busy cycle
        slv_lat = NEVER;
        pushResp(0, 32'h0, 15, -1);
        applyStimulus(RR, 0, 1'b0, 32'h20, 32'h0, 4'h0);
        checkOutput("timeout_err_set", terr_rr, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("timeout_err_sticky", terr_rr, 1);

        // Next transaction completes normally; error flag stays
        slv_lat = 1;
        pushResp(0, 32'h2468_2468, 2, -1);
        pushSreq(1'b0, 32'h30, 32'h0, 4'h0, 32'h2468_2468);
        applyStimulus(RR, 0, 1'b0, 32'h30, 32'h0, 4'h0);
        checkOutput("timeout_err_after_ok", terr_rr, 1);

        // Reset in the middle of an m1 transaction
        slv_lat = NEVER;
        drive(RR, 1, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_s_valid", s_rr.valid, 1);
        checkOutput("pre_rst_owner", owner_rr, 1);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_s_valid", s_rr.valid, 0);
        checkOutput("midrst_m1_ready", m1_rr.ready, 0);
        checkOutput("midrst_owner", owner_rr, 0);
        checkOutput("midrst_timeout_err", terr_rr, 0);
        drive(RR, 1, 1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // After reset m0 wins the first contention even though m0 was served last before it
        slv_lat = 0;
        pushResp(0, 32'h8888_0000, 1, -1);
        pushResp(1, 32'h9999_0000, 1, 1);
        pushSreq(1'b0, 32'h800, 32'h0, 4'h0, 32'h8888_0000);
        pushSreq(1'b0, 32'h900, 32'h0, 4'h0, 32'h9999_0000);
        fork
            applyStimulus(RR, 0, 1'b0, 32'h800, 32'h0, 4'h0);
            applyStimulus(RR, 1, 1'b0, 32'h900, 32'h0, 4'h0);
        join

        // Fixed priority: m0 back-to-back keeps the bus, m1 waits until m0 stops
        pushFp(0, 32'hA00);
        pushFp(0, 32'hA04);
        pushFp(0, 32'hA08);
        pushFp(1, 32'hB00);
        fork
            begin
                applyStimulus(FP, 0, 1'b0, 32'hA00, 32'h0, 4'h0);
                applyStimulus(FP, 0, 1'b0, 32'hA04, 32'h0, 4'h0);
                applyStimulus(FP, 0, 1'b0, 32'hA08, 32'h0, 4'h0);
            end
            applyStimulus(FP, 1, 1'b0, 32'hB00, 32'h0, 4'h0);
        join
        checkOutput("fp_owner", owner_fp, 1);
        checkOutput("fp_timeout_err", terr_fp, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rr_resp_queue_empty", exp_rr.size(), 0);
        checkOutput("sreq_queue_empty", exp_sreq.size(), 0);
        checkOutput("fp_resp_queue_empty", exp_fp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
